// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline-control types and constants
// Purpose: types and constants shared by the hazard unit and the pipeline
//   registers.
// Contents: hu_state_t (hazard unit FSM state), REG_X0 (hard-wired zero
//   register index), NOP_CTRL (all-zero ID/EX control word used for bubbles
//   and flushes).
package core_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hu_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Width of the ID/EX control bundle; a bubble or flush loads NOP_CTRL.
  localparam int CTRL_W = 8;
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/hu_dep_cmp.sv
// rtl/hu_dep_cmp.sv - load-use dependency compare
// Purpose: flags a load in ID/EX whose destination is read by the
//   instruction in IF/ID.
// Ports:
//   ifid_rs1, ifid_rs2  in   source register fields of the IF/ID instruction
//   ifid_uses_rs2       in   IF/ID instruction actually reads rs2
//   idex_memread        in   ID/EX instruction is a load
//   idex_rd             in   ID/EX destination register
//   lu                  out  load-use hazard detected
module hu_dep_cmp
  import core_pkg::*;
(
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_uses_rs2,
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = (idex_rd == ifid_rs1);
  // I-type instructions carry immediate bits in the rs2 slot; ignore them.
  assign rs2_hit = ifid_uses_rs2 & (idex_rd == ifid_rs2);

  // x0 is never actually written, so a load to x0 cannot create a dependency.
  assign lu = idex_memread & (idex_rd != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall and taken-branch flush control
// Purpose: stalls the front end for one cycle on a load-use hazard and
//   flushes IF/ID, ID/EX and EX/MEM for FLUSH_CYCLES cycles on a taken
//   branch; counts both events.
// Ports:
//   clk, reset                      clock, async active-high reset
//   ifid_rs1/rs2, ifid_uses_rs2     IF/ID source fields
//   idex_memread, idex_rd           ID/EX load info
//   exmem_branch                    taken branch resolved this cycle
//   pc_write, ifid_write            0 = hold PC / IF/ID
//   idex_bubble                     ID/EX captures NOP_CTRL
//   ifid_flush, idex_flush,
//   exmem_flush                     stage registers capture NOP
//   stall_count, flush_count        event counters (wrap)
module hazard_unit
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_branch,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  // The branch cycle itself is the first flush cycle, so FLUSH covers the rest.
  localparam logic [FW-1:0] FCNT_LOAD = FW'(FLUSH_CYCLES - 1);

  hu_state_t      state_q, state_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic           lu;
  logic           inc_stall;
  logic           inc_flush;

  hu_dep_cmp u_dep_cmp (
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .idex_memread  (idex_memread),
    .idex_rd       (idex_rd),
    .lu            (lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (inc_stall) stall_count <= stall_count + CNT_W'(1);
      if (inc_flush) flush_count <= flush_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    inc_stall   = 1'b0;
    inc_flush   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    case (state_q)
      RUN: begin
        if (exmem_branch) begin
          // Branch wins: the hazarding instruction is being flushed anyway.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          inc_flush   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_LOAD;
          end
        end else if (lu) begin
          // Single-cycle stall: the bubble drops idex_memread next cycle.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          inc_stall   = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        if (exmem_branch) begin
          fcnt_d    = FCNT_LOAD;
          inc_flush = 1'b1;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
          if (fcnt_q == FW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset is asynchronous, so the outputs must drop to idle immediately,
    // not just once the state register clears.
    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      inc_stall   = 1'b0;
      inc_flush   = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_uses_rs2;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic        exmem_branch;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int checks = 0;
  int errors = 0;

  // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush}
  logic [5:0] ctl;
  assign ctl = {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush};

  localparam logic [5:0] C_IDLE  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_FLUSH = 6'b110111;

  hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .idex_memread  (idex_memread),
    .idex_rd       (idex_rd),
    .exmem_branch  (exmem_branch),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .idex_bubble   (idex_bubble),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ifid_rs1      = 5'd0;
    ifid_rs2      = 5'd0;
    ifid_uses_rs2 = 1'b0;
    idex_memread  = 1'b0;
    idex_rd       = 5'd0;
    exmem_branch  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    exmem_branch = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE); end
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_count, flush_count);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_use(input logic [31:0] exp_stall);
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs2 = 5'd1; ifid_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== C_STALL) begin errors++; $display("FAIL lu_stall got %b want %b", ctl, C_STALL); end
    @(negedge clk);
    idex_memread = 1'b0; idex_rd = 5'd0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_release got %b want %b", ctl, C_IDLE); end
    checks++;
    if (stall_count !== exp_stall) begin errors++; $display("FAIL lu_count got %0d want %0d", stall_count, exp_stall); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_x0();
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL x0_ctl got %b want %b", ctl, C_IDLE); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (stall_count !== 32'd1) begin errors++; $display("FAIL x0_count got %0d want 1", stall_count); end
    @(negedge clk);
  endtask

  task automatic test_rs2();
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7; ifid_uses_rs2 = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL rs2_itype got %b want %b", ctl, C_IDLE); end
    @(negedge clk);
    ifid_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== C_STALL) begin errors++; $display("FAIL rs2_rtype got %b want %b", ctl, C_STALL); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (stall_count !== 32'd2) begin errors++; $display("FAIL rs2_count got %0d want 2", stall_count); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    // Branch with a concurrent load-use hazard: branch must win.
    exmem_branch = 1'b1; idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin errors++; $display("FAIL br_c0 got %b want %b", ctl, C_FLUSH); end
    @(negedge clk);
    exmem_branch = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin errors++; $display("FAIL br_c1 got %b want %b", ctl, C_FLUSH); end
    checks++;
    if (flush_count !== 32'd1) begin errors++; $display("FAIL br_fcount got %0d want 1", flush_count); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL br_c2 got %b want %b", ctl, C_IDLE); end
    checks++;
    if (stall_count !== 32'd2) begin errors++; $display("FAIL br_scount got %0d want 2", stall_count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [4];
    exp_seq[0] = C_FLUSH; exp_seq[1] = C_FLUSH; exp_seq[2] = C_FLUSH; exp_seq[3] = C_IDLE;
    for (int c = 0; c < 4; c++) begin
      exmem_branch = (c == 0 || c == 1);
      #1;
      checks++;
      if (ctl !== exp_seq[c]) begin errors++; $display("FAIL b2b_c%0d got %b want %b", c, ctl, exp_seq[c]); end
      @(negedge clk);
    end
    checks++;
    if (flush_count !== 32'd3) begin errors++; $display("FAIL b2b_fcount got %0d want 3", flush_count); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_flush();
    exmem_branch = 1'b1;
    @(negedge clk);
    exmem_branch = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin errors++; $display("FAIL rmf_inflush got %b want %b", ctl, C_FLUSH); end
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL rmf_ctl got %b want %b", ctl, C_IDLE); end
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL rmf_cnt got %0d/%0d want 0/0", stall_count, flush_count);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin errors++; $display("FAIL rmf_run got %b want %b", ctl, C_IDLE); end
    test_load_use(32'd1);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use(32'd1);
    test_x0();
    test_rs2();
    test_branch();
    test_back_to_back();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
